// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator with glitch-free term reload.
// Optional per-channel 16-bit tick counter output enabled by defining CLK_DIV_TICK_CNT_EN.
module clk_div_multi #(
  parameter int NUM_CH      = 3,
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 6249999
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sync_clr,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       load_pend,
  output logic [NUM_CH-1:0]       clk_out,
`ifdef CLK_DIV_TICK_CNT_EN
  output logic [NUM_CH*16-1:0]    tick_cnt,
`endif
  output logic [NUM_CH-1:0]       tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] slice;
    logic             out_q;
    logic             tick_q;
    logic             pend_q;
    logic             at_term;

    assign slice   = div_val[i*CNT_W +: CNT_W];
    assign at_term = (cnt == term);

    // A load coinciding with a terminal event keeps the active term; the new
    // shadow is adopted at the following terminal instead.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        term   <= DIV_RST;
        shadow <= DIV_RST;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (sync_clr) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
        if (div_load[i]) begin
          shadow <= slice;
          term   <= slice;
        end else begin
          term   <= shadow;
        end
      end else begin
        if (en) begin
          if (at_term) begin
            cnt    <= '0;
            out_q  <= ~out_q;
            tick_q <= ~out_q;
            if (pend_q && !div_load[i])
              term <= shadow;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
        if (div_load[i]) begin
          shadow <= slice;
          pend_q <= 1'b1;
        end else if (en && at_term) begin
          pend_q <= 1'b0;
        end
      end
    end

    assign clk_out[i]   = out_q;
    assign tick[i]      = tick_q;
    assign load_pend[i] = pend_q;

`ifdef CLK_DIV_TICK_CNT_EN
    logic [15:0] tcnt_q;

    // Counts in step with tick being raised, so it already includes the current tick.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        tcnt_q <= '0;
      else if (sync_clr)
        tcnt_q <= '0;
      else if (en && at_term && !out_q)
        tcnt_q <= tcnt_q + 16'd1;
    end

    assign tick_cnt[i*16 +: 16] = tcnt_q;
`endif
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi (NUM_CH=2, CNT_W=8, DIV_DEFAULT=2) using a scoreboard queue.
// Also checks tick_cnt when built with CLK_DIV_TICK_CNT_EN.
module tb_clk_div_multi;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int DIV_D  = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sync_clr;
  logic [15:0] div_val;
  logic [1:0]  div_load;
  logic [1:0]  load_pend;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
`ifdef CLK_DIV_TICK_CNT_EN
  logic [31:0] tick_cnt;
`endif

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_DEFAULT(DIV_D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .div_val  (div_val),
    .div_load (div_load),
    .load_pend(load_pend),
    .clk_out  (clk_out),
`ifdef CLK_DIV_TICK_CNT_EN
    .tick_cnt (tick_cnt),
`endif
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  out;
    logic [1:0]  tck;
    logic [1:0]  pend;
    logic [31:0] tcnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: half-period position per channel
  logic [7:0]  m_cnt[2];
  logic [7:0]  m_term[2];
  logic [7:0]  m_shadow[2];
  logic        m_out[2];
  logic        m_tick[2];
  logic        m_pend[2];
  logic [15:0] m_tcnt[2];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 8'd0;  m_term[c] = 8'(DIV_D); m_shadow[c] = 8'(DIV_D);
      m_out[c] = 1'b0;  m_tick[c] = 1'b0;      m_pend[c] = 1'b0;
      m_tcnt[c] = 16'd0;
    end
  endtask

  task automatic model_step(input logic e, input logic c, input logic [1:0] ld, input logic [15:0] dv);
    logic [7:0] slice;
    for (int ch = 0; ch < 2; ch++) begin
      slice = dv[ch*8 +: 8];
      if (c) begin
        m_cnt[ch] = 8'd0; m_out[ch] = 1'b0; m_tick[ch] = 1'b0; m_tcnt[ch] = 16'd0; m_pend[ch] = 1'b0;
        if (ld[ch]) m_shadow[ch] = slice;
        m_term[ch] = m_shadow[ch];
      end else begin
        m_tick[ch] = 1'b0;
        if (e) begin
          if (m_cnt[ch] == m_term[ch]) begin
            m_cnt[ch] = 8'd0;
            m_out[ch] = !m_out[ch];
            if (m_out[ch]) begin
              m_tick[ch] = 1'b1;
              m_tcnt[ch] = m_tcnt[ch] + 16'd1;
            end
            if (m_pend[ch] && !ld[ch]) begin
              m_term[ch] = m_shadow[ch];
              m_pend[ch] = 1'b0;
            end
          end else begin
            m_cnt[ch] = m_cnt[ch] + 8'd1;
          end
        end
        if (ld[ch]) begin
          m_shadow[ch] = slice;
          m_pend[ch]   = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive, let the model predict at the edge, compare at the falling edge.
  task automatic apply_stimulus(input logic e, input logic c, input logic [1:0] ld, input logic [15:0] dv);
    exp_t x;
    en = e; sync_clr = c; div_load = ld; div_val = dv;
    @(posedge clk);
    model_step(e, c, ld, dv);
    x.out  = {m_out[1], m_out[0]};
    x.tck  = {m_tick[1], m_tick[0]};
    x.pend = {m_pend[1], m_pend[0]};
    x.tcnt = {m_tcnt[1], m_tcnt[0]};
    sb.push_back(x);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_output("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_output("clk_out", 32'(clk_out), 32'(x.out));
      check_output("tick", 32'(tick), 32'(x.tck));
      check_output("load_pend", 32'(load_pend), 32'(x.pend));
`ifdef CLK_DIV_TICK_CNT_EN
      check_output("tick_cnt", tick_cnt, x.tcnt);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, 1'b0, 2'b00, 16'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] pat_out;
    logic [11:0] pat_tick;
    int budget;

    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; div_load = 2'b00; div_val = 16'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_output("reset_clk_out", 32'(clk_out), 32'd0);
    check_output("reset_tick", 32'(tick), 32'd0);
    check_output("reset_load_pend", 32'(load_pend), 32'd0);
    rst_n = 1'b1;

    // Period-6 pattern straight after reset
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1'b1, 1'b0, 2'b00, 16'h0);
      pat_out[k]  = clk_out[0];
      pat_tick[k] = tick[0];
    end
    check_output("pattern_out", 32'(pat_out), 32'h71C);
    check_output("pattern_tick", 32'(pat_tick), 32'h104);

    // ch0 load of 0 one cycle into a half-period
    apply_stimulus(1'b1, 1'b0, 2'b01, 16'h0000);
    check_output("pend_after_load", 32'(load_pend), 32'd1);
    idle(10);

    // ch1 load of 5 coinciding with a ch1 terminal event
    budget = 20;
    while (m_cnt[1] != m_term[1] && budget > 0) begin
      idle(1);
      budget--;
    end
    check_output("ch1_term_wait", 32'(budget > 0), 32'd1);
    apply_stimulus(1'b1, 1'b0, 2'b10, {8'd5, 8'd0});
    idle(20);

    // Freeze for 4 cycles mid-count
    idle(1);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b0, 2'b00, 16'h0);
    idle(12);

    // sync_clr with ch0 pending shadow=4
    apply_stimulus(1'b1, 1'b0, 2'b01, 16'h0004);
    apply_stimulus(1'b1, 1'b1, 2'b00, 16'h0);
    check_output("clr_clk_out", 32'(clk_out), 32'd0);
    check_output("clr_load_pend", 32'(load_pend), 32'd0);
    idle(12);

    // sync_clr with a simultaneous ch1 load
    apply_stimulus(1'b1, 1'b1, 2'b10, {8'd1, 8'd0});
    idle(10);

    // Mixed random traffic
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'(($urandom_range(0, 9)) != 0),
                     1'(($urandom_range(0, 29)) == 0),
                     {1'(($urandom_range(0, 7)) == 0), 1'(($urandom_range(0, 7)) == 0)},
                     {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))});
    end

`ifdef CLK_DIV_TICK_CNT_EN
    apply_stimulus(1'b1, 1'b1, 2'b11, 16'h0000);
    idle(6);
    check_output("tick_cnt_after_6", 32'(tick_cnt[15:0]), 32'd3);
`endif

    // Async reset while clk_out[0] is high and a load is pending
    budget = 30;
    while (!m_out[0] && budget > 0) begin
      idle(1);
      budget--;
    end
    check_output("high_wait", 32'(budget > 0), 32'd1);
    apply_stimulus(1'b1, 1'b0, 2'b01, 16'h0007);
    rst_n = 1'b0;
    #1;
    check_output("async_clk_out", 32'(clk_out), 32'd0);
    check_output("async_load_pend", 32'(load_pend), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel programmable clock divider and tick generator for the alarm/clock datapath.
- Each channel produces two outputs from the system clock:
  - a 50%-duty square wave, period 2*(term+1) clk cycles;
  - a one-cycle tick per full period.
- The term (half-period terminal count) is runtime-reloadable without glitches. Reloads apply only at a period boundary.
- A typical instance drives 4 Hz blink, 1 Hz seconds and 1 kHz scan/buzzer from one 50 MHz clock.

Parameters:
- NUM_CH, 3, number of independent divider channels.
- CNT_W, 32, counter/terminal width per channel.
- DIV_DEFAULT, 6249999, reset terminal count for every channel (4 Hz square at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  global count enable. Low means all channels freeze.
- sync_clr  in  1  synchronous clear of all channels.
- div_val  in  NUM_CH*CNT_W  packed new terminal values. Channel i uses bits [i*CNT_W +: CNT_W].
- div_load  in  NUM_CH  per-channel load strobe. Captures the div_val slice into a shadow register.
- load_pend  out  NUM_CH  shadow value captured but not yet active.
- clk_out  out  NUM_CH  divided square outputs (registered).
- tick  out  NUM_CH  one-cycle pulse, asserted in the same cycle clk_out[i] goes 0->1.

Behaviour:
- Reset (async): all outputs are 0.
  - cnt[i]=0, clk_out=0, tick=0, load_pend=0.
  - term[i]=DIV_DEFAULT, shadow[i]=DIV_DEFAULT.
- Per channel, every clk edge with en=1 and sync_clr=0:
  - If cnt<term: cnt increments by 1; clk_out holds.
  - If cnt==term: cnt<=0 and clk_out toggles. This is the "terminal" event.
- tick[i] is 1 for exactly the cycle after a terminal event at which clk_out becomes 1. Otherwise tick is 0.
- Load handshake:
  - div_load[i]=1 captures the slice into shadow[i] and sets load_pend[i]=1.
  - At the next terminal event, term[i]<=shadow[i] and load_pend[i]<=0. The new half-period starts exactly there, so there are no runt pulses.
  - Load in the same cycle as a terminal event: the slice is captured into shadow; the currently active term is not changed at that event; load_pend=1; the new value applies at the following terminal.
  - Load while pending: the shadow is overwritten (last write wins) and load_pend stays 1.
- Width and arithmetic:
  - term=0 gives clk_out=clk/2 and a tick every 2 cycles.
  - All comparisons are unsigned, CNT_W wide.
  - cnt never exceeds term, because a new term is only adopted when cnt resets to 0.
- en=0: cnt, clk_out, term and shadow hold, and tick=0. div_load is still captured, with load_pend set.
- sync_clr=1 (priority over en and terminal events):
  - cnt=0, clk_out=0, tick=0.
  - Any pending shadow is applied immediately: term<=shadow and load_pend<=0.
  - A div_load in the same cycle is captured after the clear: the shadow is updated, term takes the new slice, and load_pend=0.
- Channels are fully independent. There is no phase relation between channels, except that all start aligned after reset or sync_clr.
- Reset mid-period: clk_out drops to 0 immediately (async), and any pending load is discarded.

Optional Feature:
- Macro CLK_DIV_TICK_CNT_EN.
- When defined, add output port tick_cnt  out  NUM_CH*16  per-channel tick counter.
  - It increments by 1 on every tick[i] and wraps 65535->0.
  - It is cleared by reset and by sync_clr, and holds while en=0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench setup: NUM_CH=2, CNT_W=8, DIV_DEFAULT=2.
- Reset release, en=1 -> clk_out[0] pattern is 0,0,0,1,1,1 repeating (period 6 cycles); tick[0] is high one cycle per 6, coincident with each 0->1.
- At cycle 1 of a half-period, div_load[0]=1 with slice=0 -> load_pend[0] rises next cycle; the remaining half-period keeps term 2; after the terminal event clk_out[0] toggles every cycle and load_pend[0]=0; channel 1 is unaffected.
- div_load[1]=1 with slice=5 in the same cycle as a ch1 terminal -> that half-period still uses 2; the following half-period lasts 6 cycles.
- en=0 for 4 cycles mid-count -> cnt/clk_out frozen, tick=0; on re-enable, counting resumes from the frozen cnt (total period stretched by 4).
- sync_clr=1 with load_pend[0]=1 (shadow=4) -> next cycle: clk_out=0, cnt=0, load_pend=0; subsequent half-period is 5 cycles.
- With CLK_DIV_TICK_CNT_EN and term=0 -> tick_cnt[0] reaches 3 after 6 cycles; a forced value of 65535 wraps to 0 on the next tick.
